dct_sched: RTL and testbench
============================

Name: dct_sched

Overview:
- Two-requester scheduler that owns the shared 8x8 DCT engine in the EPU algorithm path.
- Arbitrates round-robin between requester 0 (luma tile fetcher) and requester 1 (chroma tile fetcher).
- Drives the engine's start/hold_end pins and the 8x8 input-mux select.
- Presents each finished block downstream (quantizer) through a valid/ready handshake carrying source id and tag; also keeps per-source block counters and a sticky watchdog error.

Parameters:
TAG_W, 4, width of the per-block tag passed through from requester to output
WAIT_MAX, 7, max cycles allowed from start to dct_finish before err_timeout is set
CNT_W, 16, width of per-requester completed-block counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset; also wired to the DCT instance reset
req_valid  input  2  per-requester block-ready; pixel array and tag held stable while high
req_tag  input  2xTAG_W  per-requester tag
req_ready  output  2  one-hot acceptance pulse, same cycle as dct_start
mux_sel  output  1  selects requester pixel array feeding the DCT in[]
dct_start  output  1  start pulse to DCT
dct_finish  input  1  DCT finish (high exactly one cycle, 2 cycles after start)
dct_hold_end  output  1  releases DCT from its hold state
out_valid  output  1  DCT coefficients valid downstream
out_ready  input  1  downstream accepts
out_src  output  1  requester index of the presented block
out_tag  output  TAG_W  tag of the presented block
busy  output  1  high in any state other than IDLE
blk_cnt0  output  CNT_W  blocks completed for requester 0
blk_cnt1  output  CNT_W  blocks completed for requester 1
err_timeout  output  1  sticky watchdog error

Behaviour:
- Reset values: state=IDLE; rr_ptr=0; all outputs 0; counters 0; err_timeout 0. Reset is synchronous only.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - If any req_valid, grant (Mealy, same cycle): assert dct_start, set req_ready[g]=1, set mux_sel=g.
  - Latch src=g and tag=req_tag[g]; go to RUN.
  - mux_sel holds the last grant while not issuing.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is rr_ptr.
  - After a grant, rr_ptr = ~g.
  - A requester never waits more than one grant.
- RUN:
  - Wait for dct_finish, then go to HOLD.
  - Watchdog counter clears on entering RUN and increments each RUN cycle.
  - If the counter reaches WAIT_MAX without finish: set err_timeout, pulse dct_hold_end once, go to IDLE. No output is produced and counters are unchanged.
- HOLD:
  - The engine is in its hold state here.
  - out_valid=1, out_src=src, out_tag=tag.
  - On out_valid & out_ready: dct_hold_end=1 combinationally in the same cycle, increment blk_cnt[src], go to IDLE.
  - out_valid is never asserted in the finish cycle, because the engine ignores hold_end there.
- Latency:
  - Start at cycle T; finish at T+2; out_valid first at T+3.
  - With out_ready=1, the handshake is at T+3 and the next start is possible at T+4, i.e. 4 cycles/block.
- Stability: out_valid, once high, stays high with stable out_src/out_tag until accepted, regardless of out_ready stalls.
- Counters wrap modulo 2^CNT_W.
- err_timeout is cleared only by rst.
- A deasserted req_valid in IDLE is ignored. Requests arriving in RUN/HOLD wait; req_ready stays 0.
- rst mid-block: the block is dropped, no hold_end is issued, and the engine is reset by the same rst.

Decomposition:
- Package epu_dct_pkg holds:
  - state enum dct_sched_state_t {IDLE, RUN, HOLD};
  - DCT_LAT=2 constant;
  - default TAG_W.
- One natural sub-module, rr_arb2: 2-way round-robin arbiter with a req vector input, gnt_idx and gnt_valid outputs, and an advance input that updates the pointer.

Test Plan:
- Single block: req_valid=01, tag=5, out_ready=1 → dct_start and req_ready=01 at T; out_valid at T+3 with out_src=0 and out_tag=5; dct_hold_end at T+3; blk_cnt0=1; busy low at T+4.
- Both requesters continuously valid with tags 1/2 → grants alternate 0,1,0,1, one start every 4 cycles; after 8 blocks blk_cnt0=blk_cnt1=4.
- Backpressure: out_ready=0 for 6 cycles after out_valid → out_valid held, tag stable, no hold_end and no new start; out_ready=1 → hold_end in that cycle, next start one cycle later.
- Watchdog: model suppresses dct_finish → after WAIT_MAX (7) RUN cycles, err_timeout=1 and one hold_end pulse; no out_valid; next request still serviced; err_timeout stays 1.
- Reset mid-HOLD: rst while out_valid=1 → next cycle out_valid=0, busy=0, counters=0, rr_ptr=0; a subsequent simultaneous request grants requester 0.
- Late arrival: req1 asserts during RUN of a req0 block → req_ready[1] stays 0 until IDLE, then is granted as the next block.

Source files
------------

// File: rtl/epu_dct_pkg.sv
// Shared types and constants for the EPU DCT engine scheduler.
package epu_dct_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } dct_sched_state_t;

    localparam int DCT_LAT       = 2;
    localparam int TAG_W_DEFAULT = 4;

endpackage

// File: rtl/dct_sched_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the preferred requester on a tie
// and flips to the other requester after every granted transfer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    logic ptr_r;

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ptr_r;
            default: gnt_idx = ptr_r;
        endcase
    end

    // Pointer update on each accepted grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= ~gnt_idx;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/dct_sched.sv
// Scheduler owning the shared 8x8 DCT engine: round-robin between the luma and
// chroma fetchers, engine start/hold_end control, downstream handshake, stats.
module dct_sched
    import epu_dct_pkg::*;
#(
    parameter int TAG_W    = TAG_W_DEFAULT,
    parameter int WAIT_MAX = 7,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic [1:0]           req_ready,
    output logic                 mux_sel,
    output logic                 dct_start,
    input  logic                 dct_finish,
    output logic                 dct_hold_end,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_src,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_cnt0,
    output logic [CNT_W-1:0]     blk_cnt1,
    output logic                 err_timeout
);

    localparam int WD_W = $clog2(WAIT_MAX + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_MAX - 1);

    dct_sched_state_t state_r, state_s;
    logic             src_r, mux_sel_r, err_r;
    logic [TAG_W-1:0] tag_r;
    logic [WD_W-1:0]  wd_cnt_r;
    logic [CNT_W-1:0] blk_cnt0_r, blk_cnt1_r;
    logic             gnt_idx_s, gnt_valid_s;
    logic             issue_s, accept_s, timeout_s;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (issue_s),
        .gnt_idx   (gnt_idx_s),
        .gnt_valid (gnt_valid_s)
    );

    // Next-state and Mealy controls; rst suppresses any start or hold_end in its cycle.
    always_comb begin
        state_s   = state_r;
        issue_s   = 1'b0;
        accept_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s && !rst) begin
                    issue_s = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (dct_finish) begin
                    state_s = HOLD;
                end else if (wd_cnt_r == WD_LAST) begin
                    timeout_s = !rst;
                    state_s   = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            HOLD: begin
                if (out_ready && !rst) begin
                    accept_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode; mux_sel follows the live grant only while a start is issued.
    always_comb begin
        dct_start    = issue_s;
        req_ready    = issue_s ? (gnt_idx_s ? 2'b10 : 2'b01) : 2'b00;
        mux_sel      = issue_s ? gnt_idx_s : mux_sel_r;
        dct_hold_end = accept_s | timeout_s;
        out_valid    = (state_r == HOLD);
        out_src      = src_r;
        out_tag      = tag_r;
        busy         = (state_r != IDLE);
        blk_cnt0     = blk_cnt0_r;
        blk_cnt1     = blk_cnt1_r;
        err_timeout  = err_r;
    end

    // State, per-block context, watchdog, counters and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            src_r      <= 1'b0;
            tag_r      <= {TAG_W{1'b0}};
            mux_sel_r  <= 1'b0;
            wd_cnt_r   <= {WD_W{1'b0}};
            blk_cnt0_r <= {CNT_W{1'b0}};
            blk_cnt1_r <= {CNT_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            if (issue_s) begin
                src_r     <= gnt_idx_s;
                tag_r     <= req_tag[gnt_idx_s];
                mux_sel_r <= gnt_idx_s;
                wd_cnt_r  <= {WD_W{1'b0}};
            end else if (state_r == RUN) begin
                wd_cnt_r  <= wd_cnt_r + WD_W'(1);
            end else begin
                wd_cnt_r  <= wd_cnt_r;
            end
            if (accept_s && !src_r) begin
                blk_cnt0_r <= blk_cnt0_r + CNT_W'(1);
            end else if (accept_s && src_r) begin
                blk_cnt1_r <= blk_cnt1_r + CNT_W'(1);
            end else begin
                blk_cnt0_r <= blk_cnt0_r;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_dct_sched.sv
// Directed bench for dct_sched with a behavioural DCT engine (finish two cycles after start).
module tb_dct_sched;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0][3:0] req_tag = 8'h00;
    logic [1:0]      req_ready;
    logic            mux_sel, dct_start, dct_hold_end, out_valid, out_src, busy, err_timeout;
    logic            dct_finish = 1'b0;
    logic            out_ready = 1'b0;
    logic [3:0]      out_tag;
    logic [15:0]     blk_cnt0, blk_cnt1;
    logic            p1 = 1'b0;
    logic            suppress = 1'b0;
    int              checks = 0;
    int              failures = 0;

    dct_sched #(.TAG_W(4), .WAIT_MAX(7), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .mux_sel(mux_sel), .dct_start(dct_start), .dct_finish(dct_finish), .dct_hold_end(dct_hold_end),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_tag(out_tag),
        .busy(busy), .blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Engine model: finish pulses exactly two cycles after start unless suppressed.
    always @(posedge clk) begin
        p1         <= dct_start;
        dct_finish <= p1 & ~suppress;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if ({blk_cnt0, blk_cnt1} !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0/0", blk_cnt0, blk_cnt1); end
        checks++; if ({err_timeout, mux_sel, dct_start, dct_hold_end, req_ready} !== 6'b0) begin failures++; $display("FAIL reset_ctrl got=%0b exp=0", {err_timeout, mux_sel, dct_start, dct_hold_end, req_ready}); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req_valid = 2'b01; req_tag = {4'd0, 4'd5}; out_ready = 1'b1; #1;
        checks++; if ({dct_start, req_ready, mux_sel} !== 4'b1010) begin failures++; $display("FAIL single_start got=%0b exp=1010", {dct_start, req_ready, mux_sel}); end
        tick(); req_valid = 2'b00; #1;
        checks++; if ({busy, dct_start} !== 2'b10) begin failures++; $display("FAIL single_run got=%0b exp=10", {busy, dct_start}); end
        tick(); #1;
        checks++; if ({dct_finish, out_valid} !== 2'b10) begin failures++; $display("FAIL single_finish_cycle got=%0b exp=10", {dct_finish, out_valid}); end
        tick(); #1;
        checks++; if ({out_valid, out_src, out_tag, dct_hold_end} !== 7'b1_0_0101_1) begin failures++; $display("FAIL single_out got=%0b exp=1001011", {out_valid, out_src, out_tag, dct_hold_end}); end
        tick(); #1;
        checks++; if ({busy, blk_cnt0} !== {1'b0, 16'd1}) begin failures++; $display("FAIL single_done busy=%0h cnt0=%0d exp 0/1", busy, blk_cnt0); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 2'b11; req_tag = {4'd2, 4'd1}; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) begin
                #1;
                if (c == 0) begin
                    checks++; if ({dct_start, req_ready} !== ((i % 2) ? 3'b110 : 3'b101)) begin failures++; $display("FAIL b2b_grant blk=%0d got=%0b", i, {dct_start, req_ready}); end
                end else if (c == 3) begin
                    checks++; if ({out_valid, out_src, out_tag, dct_hold_end} !== ((i % 2) ? 7'b1_1_0010_1 : 7'b1_0_0001_1)) begin failures++; $display("FAIL b2b_out blk=%0d got=%0b", i, {out_valid, out_src, out_tag, dct_hold_end}); end
                end else begin
                    checks++; if ({dct_start, out_valid} !== 2'b00) begin failures++; $display("FAIL b2b_idle blk=%0d c=%0d got=%0b exp=00", i, c, {dct_start, out_valid}); end
                end
                tick();
            end
        end
        req_valid = 2'b00; #1;
        checks++; if ({blk_cnt0, blk_cnt1} !== {16'd4, 16'd4}) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=4/4", blk_cnt0, blk_cnt1); end
    endtask

    task automatic test_backpressure();
        req_valid = 2'b01; req_tag = {4'd7, 4'd9}; out_ready = 1'b0; #1;
        checks++; if (dct_start !== 1'b1) begin failures++; $display("FAIL bp_start got=%0h exp=1", dct_start); end
        tick(); req_valid = 2'b10; tick(); tick();
        for (int c = 3; c < 9; c++) begin
            #1;
            checks++; if ({out_valid, out_tag, dct_hold_end, dct_start, req_ready} !== 9'b1_1001_0_0_00) begin failures++; $display("FAIL bp_stall c=%0d got=%0b exp=110010000", c, {out_valid, out_tag, dct_hold_end, dct_start, req_ready}); end
            tick();
        end
        out_ready = 1'b1; #1;
        checks++; if ({out_valid, dct_hold_end, dct_start} !== 3'b110) begin failures++; $display("FAIL bp_release got=%0b exp=110", {out_valid, dct_hold_end, dct_start}); end
        tick(); #1;
        checks++; if ({dct_start, req_ready} !== 3'b110) begin failures++; $display("FAIL bp_next_start got=%0b exp=110", {dct_start, req_ready}); end
        tick(); req_valid = 2'b00; tick(); tick(); #1;
        checks++; if ({out_valid, out_src, out_tag} !== 6'b1_1_0111) begin failures++; $display("FAIL bp_second_out got=%0b exp=110111", {out_valid, out_src, out_tag}); end
        tick(); #1;
        checks++; if ({blk_cnt0, blk_cnt1} !== {16'd5, 16'd5}) begin failures++; $display("FAIL bp_cnt got=%0d/%0d exp=5/5", blk_cnt0, blk_cnt1); end
    endtask

    task automatic test_watchdog();
        suppress = 1'b1; req_valid = 2'b01; req_tag = {4'd4, 4'd8}; out_ready = 1'b1; #1;
        checks++; if (dct_start !== 1'b1) begin failures++; $display("FAIL wd_start got=%0h exp=1", dct_start); end
        tick(); req_valid = 2'b00;
        for (int c = 1; c < 7; c++) begin
            #1;
            checks++; if ({dct_hold_end, out_valid, busy} !== 3'b001) begin failures++; $display("FAIL wd_wait c=%0d got=%0b exp=001", c, {dct_hold_end, out_valid, busy}); end
            tick();
        end
        #1;
        checks++; if ({dct_hold_end, out_valid, err_timeout} !== 3'b100) begin failures++; $display("FAIL wd_fire got=%0b exp=100", {dct_hold_end, out_valid, err_timeout}); end
        tick(); suppress = 1'b0; req_valid = 2'b10; #1;
        checks++; if ({err_timeout, dct_hold_end, dct_start, blk_cnt0} !== {3'b101, 16'd5}) begin failures++; $display("FAIL wd_after err=%0h he=%0h st=%0h cnt0=%0d", err_timeout, dct_hold_end, dct_start, blk_cnt0); end
        tick(); req_valid = 2'b00; tick(); tick(); #1;
        checks++; if ({out_valid, out_src, out_tag} !== 6'b1_1_0100) begin failures++; $display("FAIL wd_service got=%0b exp=110100", {out_valid, out_src, out_tag}); end
        tick(); #1;
        checks++; if ({err_timeout, blk_cnt1} !== {1'b1, 16'd6}) begin failures++; $display("FAIL wd_sticky err=%0h cnt1=%0d exp 1/6", err_timeout, blk_cnt1); end
    endtask

    task automatic test_reset_mid_hold();
        req_valid = 2'b01; req_tag = {4'd1, 4'd3}; out_ready = 1'b0;
        tick(); req_valid = 2'b00; tick(); tick(); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmh_hold got=%0h exp=1", out_valid); end
        tick(); rst = 1'b1; #1;
        checks++; if (dct_hold_end !== 1'b0) begin failures++; $display("FAIL rmh_no_hold_end got=%0h exp=0", dct_hold_end); end
        tick(); rst = 1'b0; #1;
        checks++; if ({out_valid, busy, err_timeout, blk_cnt0, blk_cnt1} !== 35'b0) begin failures++; $display("FAIL rmh_cleared ov=%0h busy=%0h err=%0h cnt=%0d/%0d", out_valid, busy, err_timeout, blk_cnt0, blk_cnt1); end
        req_valid = 2'b11; out_ready = 1'b1; #1;
        checks++; if ({dct_start, req_ready} !== 3'b101) begin failures++; $display("FAIL rmh_ptr_reset got=%0b exp=101", {dct_start, req_ready}); end
        tick(); req_valid = 2'b00; tick(); tick(); tick(); tick(); #1;
        checks++; if (blk_cnt0 !== 16'd1) begin failures++; $display("FAIL rmh_cnt0 got=%0d exp=1", blk_cnt0); end
    endtask

    task automatic test_late_arrival();
        req_valid = 2'b01; req_tag = {4'd6, 4'd3}; out_ready = 1'b1; #1;
        checks++; if ({dct_start, req_ready, mux_sel} !== 4'b1010) begin failures++; $display("FAIL late_first got=%0b exp=1010", {dct_start, req_ready, mux_sel}); end
        tick(); req_valid = 2'b10;
        for (int c = 1; c < 4; c++) begin
            #1;
            checks++; if ({dct_start, req_ready} !== 3'b000) begin failures++; $display("FAIL late_wait c=%0d got=%0b exp=000", c, {dct_start, req_ready}); end
            tick();
        end
        #1;
        checks++; if ({dct_start, req_ready, mux_sel} !== 4'b1101) begin failures++; $display("FAIL late_grant got=%0b exp=1101", {dct_start, req_ready, mux_sel}); end
        tick(); req_valid = 2'b00; #1;
        checks++; if (mux_sel !== 1'b1) begin failures++; $display("FAIL late_mux_hold got=%0h exp=1", mux_sel); end
        tick(); tick(); #1;
        checks++; if ({out_valid, out_src, out_tag} !== 6'b1_1_0110) begin failures++; $display("FAIL late_out got=%0b exp=110110", {out_valid, out_src, out_tag}); end
        tick(); #1;
        checks++; if ({blk_cnt0, blk_cnt1} !== {16'd2, 16'd1}) begin failures++; $display("FAIL late_cnt got=%0d/%0d exp=2/1", blk_cnt0, blk_cnt1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_watchdog();
        test_reset_mid_hold();
        test_late_arrival();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
